// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, key schedule walked backwards from the round-10 key.
// Define AES_INV_CIPHER_KEY_OUT_EN to expose the recovered cipher (round-0) key on out_key.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef AES_INV_CIPHER_KEY_OUT_EN
    output logic [127:0] out_key,
`endif
    output logic [127:0] out_data
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_inv_cipher_iter supports only NR=10 (AES-128)");
        end
    endgenerate

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   rnd_q;
    logic [127:0] st_q, key_q;
    logic [127:0] rk_next, round_out;
    logic [7:0]   rcon;

    // Table entry a sits at bit offset 8*(255-a); {~a,3'b0} is that offset.
    function automatic logic [7:0] sub_byte(input logic [7:0] a);
        logic [10:0] idx;
        idx = {~a, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] a);
        logic [10:0] idx;
        idx = {~a, 3'b000};
        return INV_SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sub_byte(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a, x2, x4, x8;
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a     = s[127-8*(4*c+r) -: 8];
                x2    = xt(a);
                x4    = xt(x2);
                x8    = xt(x4);
                m9[r] = x8 ^ a;
                mb[r] = x8 ^ x2 ^ a;
                md[r] = x8 ^ x4 ^ a;
                me[r] = x8 ^ x4 ^ x2;
            end
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return o;
    endfunction

    // Undo one forward expansion step: round-i key in, round-(i-1) key out.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3, rot;
        {w0, w1, w2, w3} = k;
        n3  = w3 ^ w2;
        n2  = w2 ^ w1;
        n1  = w1 ^ w0;
        rot = {n3[23:0], n3[31:24]};
        n0  = w0 ^ {sub_byte(rot[31:24]), sub_byte(rot[23:16]), sub_byte(rot[15:8]), sub_byte(rot[7:0])}
                 ^ {rc, 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

    // rnd counts 9..0, so the round being undone is rnd+1.
    always_comb begin
        rcon = 8'h00;
        case (rnd_q)
            4'd9:    rcon = 8'h36;
            4'd8:    rcon = 8'h1b;
            4'd7:    rcon = 8'h80;
            4'd6:    rcon = 8'h40;
            4'd5:    rcon = 8'h20;
            4'd4:    rcon = 8'h10;
            4'd3:    rcon = 8'h08;
            4'd2:    rcon = 8'h04;
            4'd1:    rcon = 8'h02;
            4'd0:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        rk_next   = inv_key_step(key_q, rcon);
        round_out = inv_shift_sub(st_q) ^ rk_next;
        if (rnd_q != 4'd0)
            round_out = inv_mix_columns(round_out);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fsm_q <= IDLE;
        else
            fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    fsm_d = RUN;
            end
            RUN: begin
                if (rnd_q == 4'd0)
                    fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '0;
            key_q <= '0;
            rnd_q <= '0;
        end else if (fsm_q == IDLE && in_valid) begin
            st_q  <= in_data ^ in_key;
            key_q <= in_key;
            rnd_q <= 4'(NR - 1);
        end else if (fsm_q == RUN) begin
            st_q  <= round_out;
            key_q <= rk_next;
            if (rnd_q != 4'd0)
                rnd_q <= rnd_q - 4'd1;
        end
    end

    assign out_data = st_q;
`ifdef AES_INV_CIPHER_KEY_OUT_EN
    assign out_key  = key_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: FIPS-197 vectors, handshake corners, reset, random round-trips.
// Checks out_key as well when AES_INV_CIPHER_KEY_OUT_EN is defined.
`timescale 1ns/1ps
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
`ifdef AES_INV_CIPHER_KEY_OUT_EN
    logic [127:0] out_key;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] sb [256];

    aes_inv_cipher_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef AES_INV_CIPHER_KEY_OUT_EN
        .out_key   (out_key),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Reference forward cipher used to generate round-trip stimulus.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic aes_encrypt(input logic [127:0] pt, input logic [127:0] key,
                               output logic [127:0] ct, output logic [127:0] rk10);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        logic [7:0]  a [4];
        {w[0], w[1], w[2], w[3]} = key;
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = u[4*((c+r)%4)+r];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
        rk10 = {w[40], w[41], w[42], w[43]};
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offers a block, returns at the negedge after the accepting edge and scrambles the inputs.
    task automatic send(input logic [127:0] d, input logic [127:0] k, output int acc);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready got %b, expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        in_key   = ~k;
    endtask

    // lat = number of clock edges from the accepting edge to the edge that samples out_valid=1.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_timeout: out_valid got %b, expected 1", out_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++;
        if (out_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h, expected 0", out_data); end
`ifdef AES_INV_CIPHER_KEY_OUT_EN
        checks++;
        if (out_key !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_key: got %h, expected 0", out_key); end
`endif
    endtask

    task automatic test_fips_c1();
        int acc, lat;
        out_ready = 1'b1;
        send(C1_CT, C1_RK, acc);
        wait_out(lat);
        checks++;
        if (lat != 11) begin errors++; $display("[TB] FAIL c1_latency: got %0d, expected 11", lat); end
        checks++;
        if (out_data !== C1_PT) begin errors++; $display("[TB] FAIL c1_data: got %h, expected %h", out_data, C1_PT); end
`ifdef AES_INV_CIPHER_KEY_OUT_EN
        checks++;
        if (out_key !== C1_KEY) begin errors++; $display("[TB] FAIL c1_key: got %h, expected %h", out_key, C1_KEY); end
`endif
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL c1_pulse: out_valid got %b, expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL c1_idle: in_ready got %b, expected 1", in_ready); end
    endtask

    task automatic test_fips_b();
        int acc, lat;
        out_ready = 1'b1;
        send(B_CT, B_RK, acc);
        wait_out(lat);
        checks++;
        if (lat != 11) begin errors++; $display("[TB] FAIL b_latency: got %0d, expected 11", lat); end
        checks++;
        if (out_data !== B_PT) begin errors++; $display("[TB] FAIL b_data: got %h, expected %h", out_data, B_PT); end
`ifdef AES_INV_CIPHER_KEY_OUT_EN
        checks++;
        if (out_key !== B_KEY) begin errors++; $display("[TB] FAIL b_key: got %h, expected %h", out_key, B_KEY); end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int acc, lat;
        out_ready = 1'b0;
        send(C1_CT, C1_RK, acc);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b, expected 1", i, out_valid); end
            checks++;
            if (out_data !== C1_PT) begin errors++; $display("[TB] FAIL bp_data[%0d]: got %h, expected %h", i, out_data, C1_PT); end
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b, expected 0", i, in_ready); end
            if (i == 1) begin
                in_valid = 1'b1;
                in_data  = B_CT;
                in_key   = B_RK;
            end
            if (i == 3) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: out_valid got %b, expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_not_accepted: in_ready got %b, expected 1", in_ready); end
        send(B_CT, B_RK, acc);
        wait_out(lat);
        checks++;
        if (out_data !== B_PT) begin errors++; $display("[TB] FAIL bp_next_data: got %h, expected %h", out_data, B_PT); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, lat, n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1_CT;
        in_key    = C1_RK;
        acc1 = cyc + 1;
        @(negedge clk);
        in_data = B_CT;
        in_key  = B_RK;
        wait_out(lat);
        checks++;
        if (out_data !== C1_PT) begin errors++; $display("[TB] FAIL b2b_first: got %h, expected %h", out_data, C1_PT); end
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc2 = cyc + 1;
        checks++;
        if (acc2 - acc1 != 12) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d, expected 12", acc2 - acc1); end
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        checks++;
        if (out_data !== B_PT) begin errors++; $display("[TB] FAIL b2b_second: got %h, expected %h", out_data, B_PT); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int acc, lat;
        out_ready = 1'b1;
        send(B_CT, B_RK, acc);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_valid: got %b, expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_run_ready: got %b, expected 1", in_ready); end
        checks++;
        if (out_data !== 128'h0) begin errors++; $display("[TB] FAIL rst_run_data: got %h, expected 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(C1_CT, C1_RK, acc);
        wait_out(lat);
        checks++;
        if (lat != 11) begin errors++; $display("[TB] FAIL rst_next_latency: got %0d, expected 11", lat); end
        checks++;
        if (out_data !== C1_PT) begin errors++; $display("[TB] FAIL rst_next_data: got %h, expected %h", out_data, C1_PT); end
        @(negedge clk);
        out_ready = 1'b0;
        send(B_CT, B_RK, acc);
        wait_out(lat);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_done_valid: got %b, expected 0", out_valid); end
        checks++;
        if (out_data !== 128'h0) begin errors++; $display("[TB] FAIL rst_done_data: got %h, expected 0", out_data); end
`ifdef AES_INV_CIPHER_KEY_OUT_EN
        checks++;
        if (out_key !== 128'h0) begin errors++; $display("[TB] FAIL rst_done_key: got %h, expected 0", out_key); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_trip();
        logic [127:0] pt, key, ct, rk10;
        int acc, lat;
        out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            aes_encrypt(pt, key, ct, rk10);
            send(ct, rk10, acc);
            wait_out(lat);
            checks++;
            if (out_data !== pt) begin errors++; $display("[TB] FAIL rt_data[%0d]: got %h, expected %h", n, out_data, pt); end
`ifdef AES_INV_CIPHER_KEY_OUT_EN
            checks++;
            if (out_key !== key) begin errors++; $display("[TB] FAIL rt_key[%0d]: got %h, expected %h", n, out_key, key); end
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
